// File: rtl/dvi_scanout.sv
// dvi_scanout: raster generator and framebuffer consumer for the DVI/TMDS encoder.
// Free-running h/v counters drive a two-stage pipeline so RGB lines up with the
// one-cycle FIFO read latency. The consumer locks only at pixel (0,0).
module dvi_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        framebuffer_ready,
    output logic        framebuffer_pull,
    input  logic [23:0] framebuffer_data,
    input  logic        framebuffer_valid,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic [23:0] vid_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [15:0] underflow_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] C_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] C_HS_BEGIN = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] C_VS_BEGIN = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lockState_t;

    logic [11:0] r_h;
    logic [10:0] r_v;
    lockState_t  r_lockState;

    logic r_s1Active;
    logic r_s1Hsync;
    logic r_s1Vsync;
    logic r_s1Pull;
    logic r_s1First;

    logic w_hEnd;
    logic w_vEnd;
    logic w_origin;
    logic w_active;
    logic w_hsync;
    logic w_vsync;
    logic w_lockNow;
    logic w_pull;

    assign w_hEnd    = (r_h == C_H_LAST);
    assign w_vEnd    = (r_v == C_V_LAST);
    assign w_origin  = (r_h == 12'd0) && (r_v == 11'd0);
    assign w_active  = (r_h < C_H_ACT) && (r_v < C_V_ACT);
    assign w_hsync   = (r_h >= C_HS_BEGIN) && (r_h < C_HS_END);
    assign w_vsync   = (r_v >= C_VS_BEGIN) && (r_v < C_VS_END);
    assign locked    = (r_lockState == ST_LOCKED);
    assign w_lockNow = locked | (framebuffer_ready & w_origin);
    assign w_pull    = w_lockNow & framebuffer_ready & w_active;

    assign framebuffer_pull = w_pull;

    // Raster counters free-run regardless of lock; v advances on each h wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= 12'd0;
            r_v <= 11'd0;
        end else begin
            r_h <= w_hEnd ? 12'd0 : r_h + 12'd1;
            if (w_hEnd) begin
                r_v <= w_vEnd ? 11'd0 : r_v + 11'd1;
            end
        end
    end

    // Lock FSM: enter only at (0,0) with ready, drop as soon as ready goes low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockState <= ST_UNLOCKED;
        end else begin
            case (r_lockState)
                ST_UNLOCKED: if (framebuffer_ready && w_origin) r_lockState <= ST_LOCKED;
                ST_LOCKED:   if (!framebuffer_ready) r_lockState <= ST_UNLOCKED;
                default:     r_lockState <= ST_UNLOCKED;
            endcase
        end
    end

    // Stage 1 holds raster state while the FIFO read for this pixel completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Active <= 1'b0;
            r_s1Hsync  <= 1'b0;
            r_s1Vsync  <= 1'b0;
            r_s1Pull   <= 1'b0;
            r_s1First  <= 1'b0;
        end else begin
            r_s1Active <= w_active;
            r_s1Hsync  <= w_hsync;
            r_s1Vsync  <= w_vsync;
            r_s1Pull   <= w_pull;
            r_s1First  <= w_origin & w_pull;
        end
    end

    // Stage 2 registers the encoder-facing outputs; missing FIFO data becomes black.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_de      <= 1'b0;
            vid_hsync   <= ~HSYNC_POL;
            vid_vsync   <= ~VSYNC_POL;
            vid_rgb     <= 24'h000000;
            frame_start <= 1'b0;
        end else begin
            vid_de      <= r_s1Active;
            vid_hsync   <= r_s1Hsync ? HSYNC_POL : ~HSYNC_POL;
            vid_vsync   <= r_s1Vsync ? VSYNC_POL : ~VSYNC_POL;
            vid_rgb     <= (r_s1Pull && framebuffer_valid) ? framebuffer_data : 24'h000000;
            frame_start <= r_s1First;
        end
    end

    // Saturating count of pulled pixels whose data never arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_count <= 16'd0;
        end else if (r_s1Pull && !framebuffer_valid && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dvi_scanout.sv
// tb_dvi_scanout: directed bench on a shrunken raster (15x8 clocks per frame).
// A FIFO model answers pulls one cycle later and pushes the pixel it returned
// onto a scoreboard; the monitor pops it two cycles after the pull.
module tb_dvi_scanout;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        framebuffer_ready = 1'b1;
    logic        framebuffer_pull;
    logic [23:0] framebuffer_data = 24'h000000;
    logic        framebuffer_valid = 1'b0;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_de;
    logic [23:0] vid_rgb;
    logic        frame_start;
    logic        locked;
    logic [15:0] underflow_count;

    typedef struct {
        int          cyc;
        logic [23:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          originCyc = 0;
    int          suppressN = 0;
    logic [23:0] nextPix = 24'h000001;

    dvi_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .framebuffer_ready(framebuffer_ready),
        .framebuffer_pull(framebuffer_pull),
        .framebuffer_data(framebuffer_data),
        .framebuffer_valid(framebuffer_valid),
        .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync),
        .vid_de(vid_de),
        .vid_rgb(vid_rgb),
        .frame_start(frame_start),
        .locked(locked),
        .underflow_count(underflow_count)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Cycle index, stable when sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic newRst, input logic newReady);
        @(posedge clk);
        #1;
        rst = newRst;
        framebuffer_ready = newReady;
    endtask

    function automatic int posNow();
        return (cyc - originCyc) % FRAME;
    endfunction

    task automatic waitPos(input int h, input int v);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (posNow() == v * HT + h) return;
        end
        checkOutput("waitPos_timeout", 32'd0, 32'd1);
    endtask

    // FIFO model: a pull seen in cycle t yields data/valid during cycle t+1.
    initial begin
        logic p;
        logic sup;
        int   c;
        forever begin
            @(negedge clk);
            p   = framebuffer_pull && !rst;
            c   = cyc;
            sup = 1'b0;
            if (p && suppressN > 0) begin
                sup = 1'b1;
                suppressN--;
            end
            @(posedge clk);
            #1;
            if (p && !sup) begin
                framebuffer_valid = 1'b1;
                framebuffer_data  = nextPix;
                q.push_back('{cyc: c, data: nextPix});
                nextPix = nextPix + 24'd1;
            end else begin
                framebuffer_valid = 1'b0;
                framebuffer_data  = 24'hABCDEF;
                if (p) q.push_back('{cyc: c, data: 24'h000000});
            end
        end
    end

    // Scoreboard monitor: each pull must surface as a de pixel two cycles later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
            end else begin
                if (q.size() > 0 && q[0].cyc + 2 == cyc) begin
                    e = q.pop_front();
                    checkOutput("sb_de", {31'd0, vid_de}, 32'd1);
                    checkOutput("sb_rgb", {8'd0, vid_rgb}, {8'd0, e.data});
                end else if (vid_de) begin
                    checkOutput("unpulled_black", {8'd0, vid_rgb}, 32'd0);
                end
                if (frame_start) checkOutput("frame_start_de", {31'd0, vid_de}, 32'd1);
            end
        end
    end

    initial begin
        int pulls, des, hsLow, vsLow, fsCnt, firstFall, secondFall, found;
        logic prevHs;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hsync", {31'd0, vid_hsync}, 32'd1);
        checkOutput("rst_vsync", {31'd0, vid_vsync}, 32'd1);
        checkOutput("rst_de", {31'd0, vid_de}, 32'd0);
        checkOutput("rst_rgb", {8'd0, vid_rgb}, 32'd0);
        checkOutput("rst_fs", {31'd0, frame_start}, 32'd0);
        checkOutput("rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("rst_ufc", {16'd0, underflow_count}, 32'd0);

        // Release with ready high: lock and pull on the very first cycle
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        originCyc = cyc;
        checkOutput("pull_at_origin", {31'd0, framebuffer_pull}, 32'd1);
        checkOutput("unlocked_at_origin", {31'd0, locked}, 32'd0);
        @(negedge clk);
        checkOutput("locked_after_origin", {31'd0, locked}, 32'd1);
        @(negedge clk);
        checkOutput("first_de", {31'd0, vid_de}, 32'd1);
        checkOutput("first_rgb", {8'd0, vid_rgb}, 32'h000001);
        checkOutput("first_fs", {31'd0, frame_start}, 32'd1);

        // One full frame of raster statistics
        pulls = 0; des = 0; hsLow = 0; vsLow = 0; fsCnt = 0;
        firstFall = -1; secondFall = -1;
        prevHs = vid_hsync;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            pulls += int'(framebuffer_pull);
            des   += int'(vid_de);
            hsLow += int'(!vid_hsync);
            vsLow += int'(!vid_vsync);
            fsCnt += int'(frame_start);
            if (prevHs && !vid_hsync) begin
                if (firstFall < 0) firstFall = i;
                else if (secondFall < 0) secondFall = i;
            end
            prevHs = vid_hsync;
        end
        checkOutput("frame_pulls", pulls, HA * VA);
        checkOutput("frame_de", des, HA * VA);
        checkOutput("frame_hsync_low", hsLow, HS * VT);
        checkOutput("frame_vsync_low", vsLow, VS * HT);
        checkOutput("frame_starts", fsCnt, 1);
        checkOutput("hsync_period", secondFall - firstFall, HT);

        // Underflow on three consecutive pulls
        found = 0;
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            @(negedge clk);
            if (framebuffer_pull) found = 1;
        end
        checkOutput("pull_seen", found, 1);
        @(posedge clk);
        #1;
        suppressN = 3;
        repeat (60) @(negedge clk);
        checkOutput("underflow_count", {16'd0, underflow_count}, 32'd3);
        checkOutput("locked_after_uf", {31'd0, locked}, 32'd1);

        // Ready drop at h=5 of line 2, restore at line 3
        waitPos(4, 2);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drop_pull", {31'd0, framebuffer_pull}, 32'd0);
        checkOutput("drop_locked_same", {31'd0, locked}, 32'd1);
        @(negedge clk);
        checkOutput("drop_locked_next", {31'd0, locked}, 32'd0);
        waitPos(HT - 1, 2);
        applyStimulus(1'b0, 1'b1);
        pulls = 0;
        found = 0;
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            @(negedge clk);
            if (posNow() == 0) found = 1;
            else pulls += int'(framebuffer_pull);
        end
        checkOutput("relock_reached", found, 1);
        checkOutput("no_pull_until_origin", pulls, 0);
        checkOutput("relock_pull", {31'd0, framebuffer_pull}, 32'd1);
        checkOutput("relock_unlocked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        checkOutput("relock_locked", {31'd0, locked}, 32'd1);

        // Reset mid-frame, then ready raised at v=2
        waitPos(7, 1);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mrst_hsync", {31'd0, vid_hsync}, 32'd1);
        checkOutput("mrst_vsync", {31'd0, vid_vsync}, 32'd1);
        checkOutput("mrst_de", {31'd0, vid_de}, 32'd0);
        checkOutput("mrst_rgb", {8'd0, vid_rgb}, 32'd0);
        checkOutput("mrst_locked", {31'd0, locked}, 32'd0);
        checkOutput("mrst_ufc", {16'd0, underflow_count}, 32'd0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        originCyc = cyc;
        checkOutput("norady_pull", {31'd0, framebuffer_pull}, 32'd0);
        waitPos(HT - 1, 1);
        applyStimulus(1'b0, 1'b1);
        pulls = 0;
        found = 0;
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            @(negedge clk);
            if (posNow() == 0) found = 1;
            else pulls += int'(framebuffer_pull);
        end
        checkOutput("midready_reached", found, 1);
        checkOutput("midready_no_pull", pulls, 0);
        checkOutput("midready_pull", {31'd0, framebuffer_pull}, 32'd1);
        checkOutput("midready_unlocked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        checkOutput("midready_locked", {31'd0, locked}, 32'd1);
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
